// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// The FSM state enum, the default operand width and the bit-counter width helper.
package serial_arith_pkg;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } serial_state_t;

  // Bit-counter width for a WIDTH-cycle serial pass; never narrower than one bit.
  function automatic int serial_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: the one arithmetic cell the serial adder reuses every cycle.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) | (c & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first, valid/ready on both sides.
// Defining SERIAL_ADDER_SUB_EN adds a 'sub' port that turns the operation into a - b - cin (borrow out on cout).
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = serial_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 2..32");
    end
  endgenerate

  serial_state_t    state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] sum_sr_reg, sum_sr_next;
  logic             carry_reg, carry_next;
  logic             out_valid_reg, out_valid_next;
  logic             sub_sel;
  logic             sub_accept;

  // Subtract mode is a - b - cin = a + ~b + ~cin: invert b into the cell and the carry seed.
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_reg, sub_next;

  assign sub_sel    = sub_reg;
  assign sub_accept = sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg <= 1'b0;
    end else begin
      sub_reg <= sub_next;
    end
  end

  always_comb begin
    sub_next = sub_reg;
    if (state_reg == IDLE && in_valid) begin
      sub_next = sub;
    end
  end
`else
  assign sub_sel    = 1'b0;
  assign sub_accept = 1'b0;
`endif

  logic fa_b, fa_s, fa_co;

  assign fa_b = b_sr_reg[0] ^ sub_sel;

  full_adder_cell u_cell (
    .a  (a_sr_reg[0]),
    .b  (fa_b),
    .c  (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // Right-shifted copies of the operand registers; the vacated MSB fills with zero.
  logic [WIDTH-1:0] a_shr, b_shr, sum_shr;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shr[gi]   = a_sr_reg[gi + 1];
      assign b_shr[gi]   = b_sr_reg[gi + 1];
      assign sum_shr[gi] = sum_sr_reg[gi + 1];
    end
  endgenerate

  assign a_shr[WIDTH-1]   = 1'b0;
  assign b_shr[WIDTH-1]   = 1'b0;
  assign sum_shr[WIDTH-1] = fa_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      sum_sr_reg    <= '0;
      carry_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      a_sr_reg      <= a_sr_next;
      b_sr_reg      <= b_sr_next;
      sum_sr_reg    <= sum_sr_next;
      carry_reg     <= carry_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_sr_next   = a_sr_reg;
    b_sr_next   = b_sr_reg;
    sum_sr_next = sum_sr_reg;
    carry_next  = carry_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_sr_next  = a;
          b_sr_next  = b;
          carry_next = cin ^ sub_accept;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_next   = a_shr;
        b_sr_next   = b_shr;
        sum_sr_next = sum_shr;
        carry_next  = fa_co;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    out_valid_next = (state_next == HOLD);
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign sum       = sum_sr_reg;
  // In subtract mode the final carry is the inverse of the borrow out.
  assign cout      = carry_reg ^ sub_sel;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random operations against an arithmetic model.
// Subtract-mode checks are built when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Reference: exact (W+1)-bit arithmetic; for subtraction bit W is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} - {1'b0, y} - (W+1)'(c);
    else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One full operation: accept, latency, result, optional stall in HOLD, completion.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic vsub, input int stall);
    logic [W:0] exp;
    int lat;
    exp = model(va, vb, vc, vsub);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'(1));
    in_valid = 1'b1; a = va; b = vb; cin = vc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = vsub;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(W));
    check("sum", 64'(sum), 64'(exp[W-1:0]));
    check("cout", 64'(cout), 64'(exp[W]));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_sum", 64'(sum), 64'(exp[W-1:0]));
      check("stall_valid_in_ready", 64'({out_valid, in_ready}), 64'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("done_valid_in_ready", 64'({out_valid, in_ready}), 64'(2'b01));
    $display("op a=%0h b=%0h cin=%0b sub=%0b -> sum=%0h cout=%0b", va, vb, vc, vsub, exp[W-1:0], exp[W]);
  endtask

  initial begin
    logic [W-1:0] va [10];
    logic [W-1:0] vb [10];
    logic         vc [10];
    logic [W:0]   exp_q [$];
    logic [W:0]   e;
    int           acc_q [$];
    int           cyc, rcv, vi, seen;

    // Reset state.
    #2;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 5);

    // Asynchronous reset during SHIFT aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'(0));
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 0);

    // Random single operation with a short stall.
    run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 2);

    // Back-to-back: in_valid and out_ready held high over 10 random vectors.
    for (int i = 0; i < 10; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = 1'($urandom);
    end
    @(negedge clk);
    vi = 0; rcv = 0; cyc = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0];
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    while (rcv < 10 && cyc < 400) begin
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_result", 64'({cout, sum}), 64'(e));
        end else begin
          check("b2b_spurious_valid", 64'(out_valid), 64'(0));
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        exp_q.push_back(model(a, b, cin, 1'b0));
        vi++;
      end
      @(posedge clk); #1;
      if (vi < 10) begin
        a = va[vi]; b = vb[vi]; cin = vc[vi];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_received", 64'(rcv), 64'(10));
    for (int i = 1; i < acc_q.size(); i++) begin
      check("b2b_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'(W + 2));
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 0);
    run_op(8'h50, 8'h20, 1'b1, 1'b1, 0);
    run_op(8'h35, 8'h4A, 1'b1, 1'b0, 0);
    run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
